uart_command_initiator: RTL and testbench

Host-side command master for the UART frame protocol decoded by the system controller. It accepts one command request, serializes the command bytes to a byte-level UART transmitter, then collects the 0/1/2 response bytes from a byte-level UART receiver. It has a per-byte response timeout. It lets on-chip logic or an FPGA host drive a remote system_top over its serial link.

---
 rtl/uart_command_initiator_if.sv | 38 +++
 rtl/uart_command_initiator.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_command_initiator.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_command_initiator_if.sv
// Command, UART byte-stream and response signals of the UART command initiator.
// The master modport is the initiator's view; slave is the host/PHY side.
interface uart_command_initiator_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int FUNCTION_WIDTH = 4
);
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [1:0]                  cmd_type;
   logic [ADDRESS_WIDTH-1:0]    cmd_address;
   logic [DATA_WIDTH-1:0]       cmd_data;
   logic [DATA_WIDTH-1:0]       cmd_operand_a;
   logic [DATA_WIDTH-1:0]       cmd_operand_b;
   logic [FUNCTION_WIDTH-1:0]   cmd_function;
   logic [DATA_WIDTH-1:0]       tx_data;
   logic                        tx_data_valid;
   logic                        tx_busy;
   logic [DATA_WIDTH-1:0]       rx_data;
   logic                        rx_data_valid;
   logic                        rx_parity_error;
   logic                        rx_frame_error;
   logic [2*DATA_WIDTH-1:0]     response_data;
   logic                        response_valid;
   logic                        response_error;

   modport master (
      input  cmd_valid, cmd_type, cmd_address, cmd_data, cmd_operand_a, cmd_operand_b,
             cmd_function, tx_busy, rx_data, rx_data_valid, rx_parity_error, rx_frame_error,
      output cmd_ready, tx_data, tx_data_valid, response_data, response_valid, response_error
   );

   modport slave (
      output cmd_valid, cmd_type, cmd_address, cmd_data, cmd_operand_a, cmd_operand_b,
             cmd_function, tx_busy, rx_data, rx_data_valid, rx_parity_error, rx_frame_error,
      input  cmd_ready, tx_data, tx_data_valid, response_data, response_valid, response_error
   );
endinterface

// File: rtl/uart_command_initiator.sv
// Host-side command master: serializes one command frame to a byte UART
// transmitter, then collects 0/1/2 response bytes with a per-byte timeout.
module uart_command_initiator #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int FUNCTION_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   uart_command_initiator_if.master bus
);
   localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [1:0] CMD_WRITE   = 2'b00;
   localparam logic [1:0] CMD_READ    = 2'b01;
   localparam logic [1:0] CMD_ALU     = 2'b10;
   localparam logic [1:0] CMD_ALU_NOP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_SEND          = 3'd1,
      S_WAIT_ACCEPT   = 3'd2,
      S_WAIT_TX_DONE  = 3'd3,
      S_WAIT_RESPONSE = 3'd4,
      S_DONE          = 3'd5
   } state_e;

   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]            ctype,
      input logic [2:0]            idx,
      input logic [DATA_WIDTH-1:0] addr_ext,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [DATA_WIDTH-1:0] op_a,
      input logic [DATA_WIDTH-1:0] op_b,
      input logic [DATA_WIDTH-1:0] func_ext
   );
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      case (ctype)
         CMD_WRITE: case (idx)
            3'd0:    b = DATA_WIDTH'(8'hAA);
            3'd1:    b = addr_ext;
            default: b = wdata;
         endcase
         CMD_READ: case (idx)
            3'd0:    b = DATA_WIDTH'(8'hBB);
            default: b = addr_ext;
         endcase
         CMD_ALU: case (idx)
            3'd0:    b = DATA_WIDTH'(8'hCC);
            3'd1:    b = op_a;
            3'd2:    b = op_b;
            default: b = func_ext;
         endcase
         CMD_ALU_NOP: case (idx)
            3'd0:    b = DATA_WIDTH'(8'hDD);
            default: b = func_ext;
         endcase
         default: b = '0;
      endcase
      return b;
   endfunction

   function automatic logic [2:0] byte_count(input logic [1:0] ctype);
      case (ctype)
         CMD_WRITE:   return 3'd3;
         CMD_READ:    return 3'd2;
         CMD_ALU:     return 3'd4;
         CMD_ALU_NOP: return 3'd2;
         default:     return 3'd2;
      endcase
   endfunction

   function automatic logic [1:0] resp_count(input logic [1:0] ctype);
      case (ctype)
         CMD_WRITE: return 2'd0;
         CMD_READ:  return 2'd1;
         default:   return 2'd2;
      endcase
   endfunction

   state_e                  state_q, state_d;
   logic [1:0]              type_q, type_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d, data_q, data_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic [DATA_WIDTH-1:0]   func_q, func_d;
   logic [2:0]              byte_idx_q, byte_idx_d;
   logic                    rx_idx_q, rx_idx_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic                    err_q, err_d;
   logic [2*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                    cmd_ready_q, cmd_ready_d, tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;

   // State, captured command, response datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         type_q       <= 2'b00;
         addr_q       <= '0;
         data_q       <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         func_q       <= '0;
         byte_idx_q   <= 3'd0;
         rx_idx_q     <= 1'b0;
         timer_q      <= '0;
         err_q        <= 1'b0;
         resp_data_q  <= '0;
         cmd_ready_q  <= 1'b1;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         type_q       <= type_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         func_q       <= func_d;
         byte_idx_q   <= byte_idx_d;
         rx_idx_q     <= rx_idx_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
         resp_data_q  <= resp_data_d;
         cmd_ready_q  <= cmd_ready_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      addr_d      = addr_q;
      data_d      = data_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      func_d      = func_q;
      byte_idx_d  = byte_idx_q;
      rx_idx_d    = rx_idx_q;
      timer_d     = timer_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d     = S_SEND;
               type_d      = bus.cmd_type;
               addr_d      = DATA_WIDTH'(bus.cmd_address);
               data_d      = bus.cmd_data;
               op_a_d      = bus.cmd_operand_a;
               op_b_d      = bus.cmd_operand_b;
               func_d      = DATA_WIDTH'(bus.cmd_function);
               byte_idx_d  = 3'd0;
               rx_idx_d    = 1'b0;
               err_d       = 1'b0;
               resp_data_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (!bus.tx_busy) begin
               state_d = S_WAIT_ACCEPT;
            end else begin
               state_d = S_SEND;
            end
         end
         S_WAIT_ACCEPT: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT_TX_DONE;
            end else begin
               state_d = S_WAIT_ACCEPT;
            end
         end
         S_WAIT_TX_DONE: begin
            if (!bus.tx_busy) begin
               byte_idx_d = byte_idx_q + 3'd1;
               if (byte_idx_d < byte_count(type_q)) begin
                  state_d = S_SEND;
               end else if (resp_count(type_q) == 2'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_RESPONSE;
                  timer_d = '0;
               end
            end else begin
               state_d = S_WAIT_TX_DONE;
            end
         end
         S_WAIT_RESPONSE: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (bus.rx_data_valid) begin
               timer_d = '0;
               err_d   = err_q | bus.rx_parity_error | bus.rx_frame_error;
               if (rx_idx_q) begin
                  resp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = bus.rx_data;
               end else begin
                  resp_data_d[DATA_WIDTH-1:0] = bus.rx_data;
               end
               if (({1'b0, rx_idx_q} + 2'd1) == resp_count(type_q)) begin
                  state_d = S_DONE;
               end else begin
                  rx_idx_d = 1'b1;
               end
            end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output next values follow the upcoming state so every output is a flop.
   always_comb begin
      cmd_ready_d  = (state_d == S_IDLE);
      tx_valid_d   = (state_d == S_WAIT_ACCEPT);
      resp_valid_d = (state_d == S_DONE);
      if ((state_q == S_SEND) && (state_d == S_WAIT_ACCEPT)) begin
         tx_data_d = frame_byte(type_q, byte_idx_q, addr_q, data_q, op_a_q, op_b_q, func_q);
      end else begin
         tx_data_d = tx_data_q;
      end
      if (state_d == S_DONE) begin
         resp_err_d = err_d;
      end else begin
         resp_err_d = 1'b0;
      end
   end

   assign bus.cmd_ready      = cmd_ready_q;
   assign bus.tx_data        = tx_data_q;
   assign bus.tx_data_valid  = tx_valid_q;
   assign bus.response_data  = resp_data_q;
   assign bus.response_valid = resp_valid_q;
   assign bus.response_error = resp_err_q;
endmodule

// File: tb/tb_uart_command_initiator.sv
// Directed bench for uart_command_initiator with a one-cycle-busy transmitter model.
module tb_uart_command_initiator;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   uart_command_initiator_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FUNCTION_WIDTH(FW)) bus ();

   uart_command_initiator #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FUNCTION_WIDTH(FW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] tx_log[$];
   int busy_cnt = 0;
   bit tx_block = 1'b0;
   int resp_pulses = 0;
   logic [15:0] last_data = 16'h0000;
   logic last_err = 1'b0;

   // Transmitter model: takes a byte when valid and idle, then is busy one cycle.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (busy_cnt > 0) begin
            busy_cnt--;
         end else if (bus.tx_data_valid === 1'b1 && !tx_block) begin
            tx_log.push_back(bus.tx_data);
            busy_cnt = 1;
         end
         bus.tx_busy = (busy_cnt > 0) || tx_block;
      end
   end

   // Response monitor.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (bus.response_valid === 1'b1) begin
            resp_pulses++;
            last_data = bus.response_data;
            last_err  = bus.response_error;
         end
      end
   end

   task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] f);
      @(negedge clk);
      bus.cmd_type = t; bus.cmd_address = a; bus.cmd_data = d;
      bus.cmd_operand_a = opa; bus.cmd_operand_b = opb; bus.cmd_function = f;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] d, input bit pe, input bit fe);
      @(negedge clk);
      bus.rx_data = d; bus.rx_parity_error = pe; bus.rx_frame_error = fe;
      bus.rx_data_valid = 1'b1;
      @(negedge clk);
      bus.rx_data_valid = 1'b0; bus.rx_parity_error = 1'b0; bus.rx_frame_error = 1'b0;
   endtask

   task automatic wait_tx(input int n, input string name);
      int k;
      k = 0;
      while (tx_log.size() < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (tx_log.size() < n) begin
         errors++;
         $display("FAIL %s tx wait: got %0d bytes, expected %0d", name, tx_log.size(), n);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_resp(input int base, input int bound, input string name, output int cycles);
      int k;
      k = 0;
      while (resp_pulses == base && k < bound) begin
         @(negedge clk);
         k++;
      end
      cycles = k;
      checks++;
      if (resp_pulses == base) begin
         errors++;
         $display("FAIL %s response timeout after %0d cycles", name, k);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (resp_pulses !== base + 1) begin
         errors++;
         $display("FAIL %s pulse count: got %0d, expected %0d", name, resp_pulses - base, 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b, expected 1", bus.cmd_ready); end
      checks++;
      if (bus.tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset tx_data_valid: got %b, expected 0", bus.tx_data_valid); end
      checks++;
      if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data: got %h, expected 00", bus.tx_data); end
      checks++;
      if (bus.response_valid !== 1'b0 || bus.response_error !== 1'b0) begin
         errors++; $display("FAIL reset response flags: got %b%b, expected 00", bus.response_valid, bus.response_error);
      end
      checks++;
      if (bus.response_data !== 16'h0000) begin errors++; $display("FAIL reset response_data: got %h, expected 0000", bus.response_data); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post-reset cmd_ready: got %b, expected 1", bus.cmd_ready); end
   endtask

   task automatic test_write();
      logic [7:0] exp[$];
      int base, cyc;
      exp = '{8'hAA, 8'h05, 8'h3C};
      tx_log.delete();
      base = resp_pulses;
      issue(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      checks++;
      if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL write busy cmd_ready: got %b, expected 0", bus.cmd_ready); end
      wait_resp(base, 200, "write", cyc);
      checks++;
      if (tx_log.size() != exp.size()) begin errors++; $display("FAIL write tx count: got %0d, expected %0d", tx_log.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL write tx byte %0d: got %h, expected %h", i, tx_log[i], exp[i]); end
      end
      checks++;
      if (last_data !== 16'h0000 || last_err !== 1'b0) begin
         errors++; $display("FAIL write response: got %h err %b, expected 0000 err 0", last_data, last_err);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL write ready return: got %b, expected 1", bus.cmd_ready); end
   endtask

   task automatic test_read();
      int base, cyc;
      tx_log.delete();
      base = resp_pulses;
      issue(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(2, "read");
      checks++;
      if (tx_log[0] !== 8'hBB || tx_log[1] !== 8'h05) begin
         errors++; $display("FAIL read tx bytes: got %h %h, expected BB 05", tx_log[0], tx_log[1]);
      end
      rx_byte(8'h3C, 1'b0, 1'b0);
      wait_resp(base, 100, "read", cyc);
      checks++;
      if (last_data !== 16'h003C || last_err !== 1'b0) begin
         errors++; $display("FAIL read response: got %h err %b, expected 003C err 0", last_data, last_err);
      end
   endtask

   task automatic test_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                           input logic [7:0] r0, input logic [7:0] r1, input logic [15:0] expd);
      logic [7:0] exp[$];
      int base, cyc;
      exp = '{8'hCC, a, b, {4'h0, f}};
      tx_log.delete();
      base = resp_pulses;
      issue(2'b10, 4'h0, 8'h00, a, b, f);
      wait_tx(4, "alu");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL alu tx byte %0d: got %h, expected %h", i, tx_log[i], exp[i]); end
      end
      rx_byte(r0, 1'b0, 1'b0);
      rx_byte(r1, 1'b0, 1'b0);
      wait_resp(base, 100, "alu", cyc);
      checks++;
      if (last_data !== expd || last_err !== 1'b0) begin
         errors++; $display("FAIL alu response: got %h err %b, expected %h err 0", last_data, last_err, expd);
      end
   endtask

   task automatic test_timeout();
      int base, cyc;
      tx_log.delete();
      base = resp_pulses;
      issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1);
      wait_tx(2, "timeout");
      checks++;
      if (tx_log[0] !== 8'hDD || tx_log[1] !== 8'h01) begin
         errors++; $display("FAIL timeout tx bytes: got %h %h, expected DD 01", tx_log[0], tx_log[1]);
      end
      rx_byte(8'h05, 1'b0, 1'b0);
      wait_resp(base, TO + 40, "timeout", cyc);
      checks++;
      if (cyc < TO - 4) begin errors++; $display("FAIL timeout early: got %0d cycles, expected at least %0d", cyc, TO - 4); end
      checks++;
      if (last_data !== 16'h0005 || last_err !== 1'b1) begin
         errors++; $display("FAIL timeout response: got %h err %b, expected 0005 err 1", last_data, last_err);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout ready: got %b, expected 1", bus.cmd_ready); end
   endtask

   task automatic test_frame_error();
      int base, cyc;
      tx_log.delete();
      base = resp_pulses;
      issue(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(2, "frame_err");
      rx_byte(8'h77, 1'b0, 1'b1);
      wait_resp(base, 100, "frame_err", cyc);
      checks++;
      if (last_data !== 16'h0077 || last_err !== 1'b1) begin
         errors++; $display("FAIL frame_err response: got %h err %b, expected 0077 err 1", last_data, last_err);
      end
      base = resp_pulses;
      rx_byte(8'h99, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.response_data !== 16'h0077 || resp_pulses !== base) begin
         errors++; $display("FAIL stray_rx: got %h pulses %0d, expected 0077 pulses 0", bus.response_data, resp_pulses - base);
      end
   endtask

   task automatic test_send_hold();
      logic [7:0] exp[$];
      int base, cyc, bad;
      exp = '{8'hAA, 8'h07, 8'h55};
      tx_log.delete();
      tx_block = 1'b1;
      repeat (2) @(negedge clk);
      base = resp_pulses;
      issue(2'b00, 4'h7, 8'h55, 8'h00, 8'h00, 4'h0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.tx_data_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || tx_log.size() != 0) begin
         errors++; $display("FAIL send_hold: got %0d valid cycles %0d bytes, expected 0 and 0", bad, tx_log.size());
      end
      tx_block = 1'b0;
      wait_resp(base, 200, "send_hold", cyc);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL send_hold tx byte %0d: got %h, expected %h", i, tx_log[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int base, cyc;
      tx_log.delete();
      base = resp_pulses;
      issue(2'b10, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
      while (tx_log.size() < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.tx_data_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
         errors++; $display("FAIL reset_mid tx side: got ready %b valid %b data %h, expected 1 0 00",
                            bus.cmd_ready, bus.tx_data_valid, bus.tx_data);
      end
      checks++;
      if (bus.response_valid !== 1'b0 || bus.response_data !== 16'h0000) begin
         errors++; $display("FAIL reset_mid response: got %b %h, expected 0 0000", bus.response_valid, bus.response_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (resp_pulses !== base) begin errors++; $display("FAIL reset_mid pulse: got %0d, expected 0", resp_pulses - base); end
      tx_log.delete();
      issue(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(2, "reset_mid_read");
      checks++;
      if (tx_log[0] !== 8'hBB || tx_log[1] !== 8'h09) begin
         errors++; $display("FAIL reset_mid_read tx: got %h %h, expected BB 09", tx_log[0], tx_log[1]);
      end
      rx_byte(8'hAB, 1'b0, 1'b0);
      wait_resp(base, 100, "reset_mid_read", cyc);
      checks++;
      if (last_data !== 16'h00AB || last_err !== 1'b0) begin
         errors++; $display("FAIL reset_mid_read response: got %h err %b, expected 00AB err 0", last_data, last_err);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_type = 2'b00; bus.cmd_address = 4'h0; bus.cmd_data = 8'h00;
      bus.cmd_operand_a = 8'h00; bus.cmd_operand_b = 8'h00; bus.cmd_function = 4'h0;
      bus.rx_data = 8'h00; bus.rx_data_valid = 1'b0;
      bus.rx_parity_error = 1'b0; bus.rx_frame_error = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_alu(8'h12, 8'h34, 4'h0, 8'h46, 8'h00, 16'h0046);
      test_alu(8'h10, 8'h20, 4'h2, 8'h00, 8'h02, 16'h0200);
      test_timeout();
      test_frame_error();
      test_send_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
